scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 80 ++++++++
 tb/tb_scan_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
// Scan mode holds each output for DWELL enabled cycles, then advances.
module scan_decoder #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      A,
    input  logic              E,
    input  logic              MODE,
    output logic [(1<<N)-1:0] Y,
    output logic [N-1:0]      IDX,
    output logic              WRAP
);

    localparam int W = 1 << N;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   idx_q, idx_n;
    logic [7:0]     dwell_q, dwell_n;
    logic [W-1:0]   y_q, y_n;
    logic           wrap_q, wrap_n;
    logic [N-1:0]   idx_inc;

    assign idx_inc = idx_q + 1'b1;

    // State, index, dwell and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DIRECT;
            idx_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            dwell_q <= dwell_n;
            y_q     <= y_n;
            wrap_q  <= wrap_n;
        end
    end

    // Next-state: direct/entry load A, otherwise pause, dwell or advance.
    always_comb begin
        state_n = MODE ? ST_SCAN : ST_DIRECT;
        idx_n   = idx_q;
        dwell_n = dwell_q;
        y_n     = y_q;
        wrap_n  = 1'b0;
        if (!MODE || state_q == ST_DIRECT) begin
            idx_n   = A;
            dwell_n = '0;
            y_n     = E ? (ONE << A) : '0;
        end else if (!E) begin
            y_n = '0;
        end else if (dwell_q >= DWELL_LAST) begin
            dwell_n = '0;
            idx_n   = idx_inc;
            y_n     = ONE << idx_inc;
            wrap_n  = (idx_q == {N{1'b1}});
        end else begin
            dwell_n = dwell_q + 8'd1;
            y_n     = ONE << idx_q;
        end
    end

    assign Y    = y_q;
    assign IDX  = idx_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder: N=2/DWELL=4 main instance
// plus an N=3/DWELL=1 instance for the fast-scan walk.
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic       e;
    logic       mode;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;

    logic [2:0] a3;
    logic       e3;
    logic       mode3;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       wrap3;

    int pass_cnt = 0;
    int total_cnt = 0;

    scan_decoder #(.N(2), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .E(e), .MODE(mode),
        .Y(y), .IDX(idx), .WRAP(wrap)
    );

    scan_decoder #(.N(3), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .A(a3), .E(e3), .MODE(mode3),
        .Y(y3), .IDX(idx3), .WRAP(wrap3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 2'd3; e = 1'b1; mode = 1'b0;
        a3 = 3'd0; e3 = 1'b1; mode3 = 1'b0;
        #2;
        total_cnt++;
        if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0)
            $display("FAIL reset: y=%b idx=%0d wrap=%b want 0000/0/0", y, idx, wrap);
        else pass_cnt++;
        total_cnt++;
        if (y3 !== 8'h00 || idx3 !== 3'd0 || wrap3 !== 1'b0)
            $display("FAIL reset3: y=%b idx=%0d wrap=%b want 0/0/0", y3, idx3, wrap3);
        else pass_cnt++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_direct();
        mode = 1'b0; e = 1'b1; a = 2'b10;
        step();
        total_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2 || wrap !== 1'b0)
            $display("FAIL direct_on: y=%b idx=%0d wrap=%b want 0100/2/0", y, idx, wrap);
        else pass_cnt++;
        e = 1'b0;
        step();
        total_cnt++;
        if (y !== 4'b0000 || idx !== 2'd2)
            $display("FAIL direct_off: y=%b idx=%0d want 0000/2", y, idx);
        else pass_cnt++;
        e = 1'b1; a = 2'b11;
        step();
        total_cnt++;
        if (y !== 4'b1000 || idx !== 2'd3)
            $display("FAIL direct_a3: y=%b idx=%0d want 1000/3", y, idx);
        else pass_cnt++;
    endtask

    task automatic test_scan();
        logic [1:0] ei;
        logic [3:0] ey;
        mode = 1'b0; e = 1'b1; a = 2'b00;
        step();
        mode = 1'b1; a = 2'b01;
        for (int c = 0; c <= 12; c++) begin
            step();
            a = 2'b00;
            ei = 2'((1 + c / 4) % 4);
            ey = 4'b0001 << ei;
            total_cnt++;
            if (y !== ey || idx !== ei || wrap !== (c == 12))
                $display("FAIL scan c=%0d: y=%b idx=%0d wrap=%b want %b/%0d/%b",
                         c, y, idx, wrap, ey, ei, (c == 12));
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (y !== 4'b0001 || wrap !== 1'b0)
            $display("FAIL scan_wrap_once: y=%b wrap=%b want 0001/0", y, wrap);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        mode = 1'b0; e = 1'b1;
        step();
        mode = 1'b1; a = 2'b01;
        step();
        step();
        e = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++;
            if (y !== 4'b0000 || idx !== 2'd1 || wrap !== 1'b0)
                $display("FAIL pause c=%0d: y=%b idx=%0d wrap=%b want 0000/1/0",
                         c, y, idx, wrap);
            else pass_cnt++;
        end
        e = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if (y !== 4'b0010 || idx !== 2'd1)
                $display("FAIL resume c=%0d: y=%b idx=%0d want 0010/1", c, y, idx);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2)
            $display("FAIL resume_adv: y=%b idx=%0d want 0100/2", y, idx);
        else pass_cnt++;
    endtask

    task automatic test_entry_disabled();
        mode = 1'b0; e = 1'b1;
        step();
        mode = 1'b1; a = 2'b10; e = 1'b0;
        step();
        step();
        total_cnt++;
        if (y !== 4'b0000 || idx !== 2'd2)
            $display("FAIL entry_e0: y=%b idx=%0d want 0000/2", y, idx);
        else pass_cnt++;
        e = 1'b1;
        step();
        total_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2)
            $display("FAIL entry_rise: y=%b idx=%0d want 0100/2", y, idx);
        else pass_cnt++;
        step();
        step();
        step();
        total_cnt++;
        if (y !== 4'b1000 || idx !== 2'd3)
            $display("FAIL entry_adv: y=%b idx=%0d want 1000/3", y, idx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; e = 1'b1;
        step();
        mode = 1'b1; a = 2'b11;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0)
            $display("FAIL reset_mid: y=%b idx=%0d wrap=%b want 0000/0/0", y, idx, wrap);
        else pass_cnt++;
        a = 2'b10;
        #3 rst_n = 1'b1;
        step();
        total_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2 || wrap !== 1'b0)
            $display("FAIL reset_reentry: y=%b idx=%0d wrap=%b want 0100/2/0", y, idx, wrap);
        else pass_cnt++;
        step();
        total_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2)
            $display("FAIL reset_hold: y=%b idx=%0d want 0100/2", y, idx);
        else pass_cnt++;
    endtask

    task automatic test_exit();
        mode = 1'b0; e = 1'b1;
        step();
        mode = 1'b1; a = 2'b11;
        step();
        step();
        step();
        step();
        mode = 1'b0; a = 2'b00;
        step();
        total_cnt++;
        if (y !== 4'b0001 || idx !== 2'd0 || wrap !== 1'b0)
            $display("FAIL exit: y=%b idx=%0d wrap=%b want 0001/0/0", y, idx, wrap);
        else pass_cnt++;
    endtask

    task automatic test_dwell1();
        logic [2:0] ei;
        logic [7:0] ey;
        mode3 = 1'b0; e3 = 1'b1; a3 = 3'b000;
        step();
        mode3 = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            step();
            ei = 3'(c % 8);
            ey = 8'h01 << ei;
            total_cnt++;
            if (y3 !== ey || idx3 !== ei || wrap3 !== (c != 0 && ei == 3'd0))
                $display("FAIL walk c=%0d: y=%b idx=%0d wrap=%b want %b/%0d/%b",
                         c, y3, idx3, wrap3, ey, ei, (c != 0 && ei == 3'd0));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_pause();
        test_entry_disabled();
        test_reset_mid();
        test_exit();
        test_dwell1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
